// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store sequencer between the CPU control
// FSM and the data RAM. Handles byte/halfword/word accesses with alignment
// checking, lane replication for stores and lane extraction plus sign/zero
// extension for loads. All outputs are registered.
module mem_access_unit #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_ERR    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   // Alignment rule: halfwords on even addresses, words on multiples of 4,
   // size code 11 is never legal.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
      logic res;
      case (sz)
         2'b00:   res = 1'b0;
         2'b01:   res = a[0];
         2'b10:   res = (a != 2'b00);
         default: res = 1'b1;
      endcase
      return res;
   endfunction

   // Byte-lane enables for an aligned access.
   function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] a);
      logic [3:0] res;
      case (sz)
         2'b00:   res = 4'b0001 << a;
         2'b01:   res = a[1] ? 4'b1100 : 4'b0011;
         default: res = 4'b1111;
      endcase
      return res;
   endfunction

   // Replicate right-justified store data across every lane it could occupy.
   function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] res;
      case (sz)
         2'b00:   res = {4{d[7:0]}};
         2'b01:   res = {2{d[15:0]}};
         default: res = d;
      endcase
      return res;
   endfunction

   // Pull the addressed lane down to bit 0 and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] a,
                                                input logic sext, input logic [31:0] word);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {a, 3'b000};
      case (sz)
         2'b00:   res = sext ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
         2'b01:   res = sext ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   state_t      state_r, state_s;
   logic [31:0] addr_r, wdata_r;
   logic        we_r, sign_ext_r;
   logic [1:0]  size_r;
   logic [3:0]  cnt_r;

   logic        accept_s, misaligned_s, load_done_s;
   logic [31:0] eff_addr_s, eff_wdata_s;
   logic [1:0]  eff_size_s;
   logic        eff_we_s;

   logic        busy_s, done_s, err_s, mem_en_s, mem_we_s;
   logic [3:0]  mem_be_s;
   logic [29:0] mem_addr_s;
   logic [31:0] mem_wdata_s;

   logic        busy_r, done_r, err_r, mem_en_r, mem_we_r;
   logic [3:0]  mem_be_r;
   logic [29:0] mem_addr_r;
   logic [31:0] mem_wdata_r, rdata_r;

   assign accept_s     = (state_r == S_IDLE) && req;
   assign misaligned_s = is_misaligned(size, addr[1:0]);
   assign load_done_s  = (state_r == S_ACCESS) && (cnt_r == 4'd0) && !we_r;

   // On the accept edge the latches are still loading, so use the live inputs.
   assign eff_addr_s  = accept_s ? addr  : addr_r;
   assign eff_wdata_s = accept_s ? wdata : wdata_r;
   assign eff_size_s  = accept_s ? size  : size_r;
   assign eff_we_s    = accept_s ? we    : we_r;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (req) begin
               if (misaligned_s) begin
                  state_s = S_ERR;
               end else begin
                  state_s = S_ACCESS;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (cnt_r == 4'd0) begin
               state_s = S_DONE;
            end else begin
               state_s = S_ACCESS;
            end
         end
         S_ERR:   state_s = S_IDLE;
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so registered outputs line up with it.
   always_comb begin
      busy_s      = (state_s != S_IDLE);
      done_s      = 1'b0;
      err_s       = 1'b0;
      mem_en_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_be_s    = 4'b0000;
      mem_addr_s  = 30'd0;
      mem_wdata_s = 32'd0;
      case (state_s)
         S_ACCESS: begin
            mem_en_s    = 1'b1;
            mem_we_s    = eff_we_s;
            mem_be_s    = byte_enables(eff_size_s, eff_addr_s[1:0]);
            mem_addr_s  = eff_addr_s[31:2];
            mem_wdata_s = replicate(eff_size_s, eff_wdata_s);
         end
         S_ERR: begin
            done_s = 1'b1;
            err_s  = 1'b1;
         end
         S_DONE: begin
            done_s = 1'b1;
         end
         default: begin
            done_s = 1'b0;
         end
      endcase
   end

   // Request capture and wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r     <= 32'd0;
         wdata_r    <= 32'd0;
         we_r       <= 1'b0;
         size_r     <= 2'b00;
         sign_ext_r <= 1'b0;
         cnt_r      <= 4'd0;
      end else if (accept_s) begin
         addr_r     <= addr;
         wdata_r    <= wdata;
         we_r       <= we;
         size_r     <= size;
         sign_ext_r <= sign_ext;
         cnt_r      <= CNT_LOAD;
      end else if ((state_r == S_ACCESS) && (cnt_r != 4'd0)) begin
         cnt_r <= cnt_r - 4'd1;
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_be_r    <= 4'b0000;
         mem_addr_r  <= 30'd0;
         mem_wdata_r <= 32'd0;
      end else begin
         busy_r      <= busy_s;
         done_r      <= done_s;
         err_r       <= err_s;
         mem_en_r    <= mem_en_s;
         mem_we_r    <= mem_we_s;
         mem_be_r    <= mem_be_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
      end
   end

   // Load result capture at the end of the last access cycle; held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r <= 32'd0;
      end else if (load_done_s) begin
         rdata_r <= load_extract(size_r, addr_r[1:0], sign_ext_r, mem_rdata);
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;
   assign rdata     = rdata_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_be    = mem_be_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle memory access sequencer between the CPU control FSM and the data RAM. It accepts one load or store request at a time and handles byte, halfword and word sizes with alignment checking. For loads it performs byte-lane extraction and sign or zero extension, then presents a 32-bit result on `rdata` for the MDR to capture. It waits a fixed number of RAM cycles and signals completion with a one-cycle `done` pulse.

## Interface
- `WAIT_CYCLES`, default 2: number of cycles `mem_en` is held per access; legal range is 1 to 15.
- `clk`, input, 1: CPU clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `req`, input, 1: start an access; sampled only in IDLE.
- `we`, input, 1: 1 = store, 0 = load.
- `size`, input, 2: 00 = byte, 01 = halfword, 10 = word; 11 is treated as misaligned.
- `sign_ext`, input, 1: for loads, 1 = sign-extend, 0 = zero-extend.
- `addr`, input, 32: byte address.
- `wdata`, input, 32: store data, right-justified.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `err`, output, 1: misaligned flag; valid only with `done`.
- `rdata`, output, 32: aligned and extended load result; held until the next load completes.
- `mem_en`, output, 1: RAM enable.
- `mem_we`, output, 1: RAM write enable.
- `mem_be`, output, 4: byte enables; bit k selects byte lane `[8k+7:8k]`.
- `mem_addr`, output, 30: word address, equal to `addr[31:2]`.
- `mem_wdata`, output, 32: lane-replicated store data.
- `mem_rdata`, input, 32: RAM read word; valid in the last ACCESS cycle.

## Operation
- FSM states and transitions:
  - IDLE → ACCESS when `req` is high and the request is aligned.
  - IDLE → ERR when `req` is high and the request is misaligned.
  - ACCESS → DONE when the wait counter reaches 0.
  - ERR → IDLE.
  - DONE → IDLE.
- On acceptance, the unit registers `addr`, `we`, `size`, `sign_ext` and `wdata`. Later changes on these inputs have no effect on the access in flight.
- Misaligned conditions are: halfword with `addr[0]`=1; word with `addr[1:0]`≠0; `size`=11.
- ERR behaviour: no RAM activity (`mem_en`=0). `done`=1 and `err`=1 for one cycle. `rdata` is unchanged.
- ACCESS behaviour:
  - `mem_en`=1 and `mem_we`=`we`; `mem_addr` and `mem_be` are driven from the latched values.
  - The counter is loaded with `WAIT_CYCLES`-1 on entry and decrements each cycle.
- Byte enables:
  - byte: `mem_be` = 0001 shifted left by `addr[1:0]`.
  - halfword: 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - word: 1111.
  - Loads drive `mem_be` identically.
- Store data replication:
  - byte: `wdata[7:0]` copied into all 4 lanes.
  - halfword: `wdata[15:0]` copied into both halves.
  - word: `wdata` as-is.
- Loads: in the last ACCESS cycle, select the lane given by the latched address. Extend to 32 bits using bit 7 (byte) or bit 15 (halfword) when `sign_ext`=1; otherwise zero-fill. Register the result into `rdata`.
- Stores: `rdata` is unchanged.
- DONE: `done`=1 and `err`=0 for one cycle; `mem_en`=0.
- `req` is ignored in ACCESS, ERR and DONE; it is not queued.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_en`, `mem_we` = 0; `mem_be`=0000; `mem_addr`=0; `mem_wdata`=0; `rdata`=0x00000000.
- Accepted request with `req` high in cycle 0:
  - ACCESS occupies cycles 1 to `WAIT_CYCLES`.
  - `done` is high in cycle `WAIT_CYCLES`+1.
  - The earliest next accept is `req` sampled in cycle `WAIT_CYCLES`+2.
- For `WAIT_CYCLES`=2, that gives: ACCESS in cycles 1–2, `done` in cycle 3, next accept at cycle 4.
- Misaligned request in cycle 0: ERR with `done`=`err`=1 in cycle 1; next accept at cycle 2.
- `rdata` is valid in the same cycle as `done`. The MDR captures it on the edge that ends the `done` cycle.
- The RAM commits a store on the edge that ends the last ACCESS cycle.
- `rst` asserted mid-access: on the next edge the FSM returns to IDLE and all outputs take their reset values. No `done` pulse is issued for the aborted access.
- `rst` and `req` high on the same edge: reset wins and the request is dropped.

## Test plan
- Reset, then word load: `WAIT_CYCLES`=2, `addr`=0x10, RAM word = 0x8899AABB. Expect `mem_be`=1111 for 2 cycles, then `done` in cycle 3 with `rdata`=0x8899AABB.
- Byte load with sign extension: `addr`=0x13, `sign_ext`=1, RAM word = 0x8899AABB. Expect `mem_be`=1000 and `rdata`=0xFFFFFF88. Repeat with `sign_ext`=0: expect `rdata`=0x00000088.
- Halfword store: `addr`=0x22, `wdata`=0x1234ABCD. Expect `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_addr`=0x8. After `done`, `rdata` is unchanged.
- Misaligned word request at `addr`=0x06. Expect `done`=`err`=1 in the next cycle and `mem_en` never asserted. A second `req` during ERR is ignored.
- Assert `rst` in the second ACCESS cycle. Expect all outputs at reset values on the next edge and no `done`. A subsequent request completes normally.
- Back-to-back: hold `req` high continuously. Expect accepts at cycles 0, 4 and 8 (`WAIT_CYCLES`=2), `busy` low only in cycles 4 and 8, and one `done` per access.
